aes_wb_master: RTL and testbench

//  Wishbone classic (B4, non-pipelined) initiator that drives one AES operation on the fossiAES

---
 rtl/aes_wb_master.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_aes_wb_master.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_wb_master.sv
// aes_wb_master
//   Wishbone classic (B4, non-pipelined) initiator that runs one AES operation
//   on the fossiAES slave: key writes (optional), data writes, start, status
//   poll and result read-back. One command is in flight at a time.
// Ports
//   clock, reset                 rising-edge clock, async active-low reset
//   io_cmd_*                     command handshake (valid/ready) plus key, data,
//                                decrypt and reuse_key fields
//   io_rsp_valid/data/error      one-cycle result pulse; error=1 on abort
//   io_wbm_*                     Wishbone master bus toward the aes slave
module aes_wb_master #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          ACK_TIMEOUT = 16,
  parameter int          POLL_MAX    = 1024
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_cmd_valid,
  output logic         io_cmd_ready,
  input  logic         io_cmd_decrypt,
  input  logic         io_cmd_reuse_key,
  input  logic [127:0] io_cmd_key,
  input  logic [127:0] io_cmd_data,
  output logic         io_rsp_valid,
  output logic [127:0] io_rsp_data,
  output logic         io_rsp_error,
  output logic         io_wbm_cyc_o,
  output logic         io_wbm_stb_o,
  output logic         io_wbm_we_o,
  output logic [3:0]   io_wbm_sel_o,
  output logic [31:0]  io_wbm_adr_o,
  output logic [31:0]  io_wbm_dat_o,
  input  logic [31:0]  io_wbm_dat_i,
  input  logic         io_wbm_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_KEY  = 3'd1,
    S_WR_DIN  = 3'd2,
    S_WR_CTRL = 3'd3,
    S_POLL    = 3'd4,
    S_RD_DOUT = 3'd5,
    S_RESP    = 3'd6
  } state_t;

  localparam logic [15:0] TO_LAST   = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] POLL_LAST = 16'(POLL_MAX - 1);

  // Word 0 is the most significant word and maps to the lowest address.
  function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      2'd3:    w = blk[31:0];
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  function automatic logic [127:0] put_word(input logic [127:0] blk, input logic [1:0] idx,
                                            input logic [31:0] w);
    logic [127:0] r;
    r = blk;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      2'd3:    r[31:0]   = w;
      default: r = blk;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] access_offset(input state_t st, input logic [1:0] idx);
    logic [31:0] o;
    case (st)
      S_WR_KEY:  o = {28'd0, idx, 2'b00};
      S_WR_DIN:  o = 32'h10 + {28'd0, idx, 2'b00};
      S_WR_CTRL: o = 32'h20;
      S_POLL:    o = 32'h24;
      S_RD_DOUT: o = 32'h28 + {28'd0, idx, 2'b00};
      default:   o = 32'h0;
    endcase
    return o;
  endfunction

  state_t         state_r, state_s;
  logic           cyc_r, cyc_s;
  logic           we_r, we_s;
  logic [31:0]    adr_r, adr_s;
  logic [31:0]    dat_r, dat_s;
  logic [1:0]     idx_r, idx_s;
  logic [15:0]    to_cnt_r, to_cnt_s;
  logic [15:0]    poll_cnt_r, poll_cnt_s;
  logic [127:0]   key_r, key_s;
  logic [127:0]   din_r, din_s;
  logic           dec_r, dec_s;
  logic [127:0]   result_r, result_s;
  logic           err_r, err_s;
  logic           rsp_valid_r, rsp_valid_s;
  logic           ready_r, ready_s;
  logic           ack_s;
  logic           timeout_s;
  logic           last_word_s;

  // An ack only counts while the strobe is up; a stray ack between accesses is ignored.
  assign ack_s       = cyc_r & io_wbm_ack_i;
  assign timeout_s   = cyc_r & ~io_wbm_ack_i & (to_cnt_r == TO_LAST);
  assign last_word_s = (idx_r == 2'd3);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (io_cmd_valid) begin
          state_s = io_cmd_reuse_key ? S_WR_DIN : S_WR_KEY;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WR_KEY: begin
        if (timeout_s)                  state_s = S_RESP;
        else if (ack_s && last_word_s)  state_s = S_WR_DIN;
        else                            state_s = S_WR_KEY;
      end
      S_WR_DIN: begin
        if (timeout_s)                  state_s = S_RESP;
        else if (ack_s && last_word_s)  state_s = S_WR_CTRL;
        else                            state_s = S_WR_DIN;
      end
      S_WR_CTRL: begin
        if (timeout_s)  state_s = S_RESP;
        else if (ack_s) state_s = S_POLL;
        else            state_s = S_WR_CTRL;
      end
      S_POLL: begin
        if (timeout_s)                                state_s = S_RESP;
        else if (ack_s && io_wbm_dat_i[0])           state_s = S_RD_DOUT;
        else if (ack_s && (poll_cnt_r == POLL_LAST)) state_s = S_RESP;
        else                                          state_s = S_POLL;
      end
      S_RD_DOUT: begin
        if (timeout_s)                  state_s = S_RESP;
        else if (ack_s && last_word_s)  state_s = S_RESP;
        else                            state_s = S_RD_DOUT;
      end
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Next values of the bus, datapath and response registers.
  always_comb begin
    cyc_s       = cyc_r;
    we_s        = we_r;
    adr_s       = adr_r;
    dat_s       = dat_r;
    idx_s       = idx_r;
    to_cnt_s    = to_cnt_r;
    poll_cnt_s  = poll_cnt_r;
    key_s       = key_r;
    din_s       = din_r;
    dec_s       = dec_r;
    result_s    = result_r;
    err_s       = err_r;
    rsp_valid_s = 1'b0;
    ready_s     = ready_r;
    case (state_r)
      S_IDLE: begin
        if (io_cmd_valid) begin
          key_s    = io_cmd_key;
          din_s    = io_cmd_data;
          dec_s    = io_cmd_decrypt;
          idx_s    = 2'd0;
          result_s = 128'd0;
          err_s    = 1'b0;
          ready_s  = 1'b0;
        end else begin
          ready_s  = 1'b1;
        end
      end
      S_WR_KEY, S_WR_DIN, S_WR_CTRL, S_POLL, S_RD_DOUT: begin
        if (!cyc_r) begin
          // Launch the next access; the cycle just spent low is the inter-access gap.
          cyc_s    = 1'b1;
          to_cnt_s = 16'd0;
          we_s     = (state_r != S_POLL) && (state_r != S_RD_DOUT);
          adr_s    = BASE_ADDR + access_offset(state_r, idx_r);
          case (state_r)
            S_WR_KEY:  dat_s = word_of(key_r, idx_r);
            S_WR_DIN:  dat_s = word_of(din_r, idx_r);
            S_WR_CTRL: dat_s = {30'd0, dec_r, 1'b1};
            default:   dat_s = 32'd0;
          endcase
        end else if (io_wbm_ack_i) begin
          cyc_s = 1'b0;
          case (state_r)
            S_WR_KEY, S_WR_DIN: idx_s = idx_r + 2'd1;
            S_WR_CTRL:          poll_cnt_s = 16'd0;
            S_POLL: begin
              if (io_wbm_dat_i[0]) begin
                idx_s = 2'd0;
              end else if (poll_cnt_r == POLL_LAST) begin
                err_s       = 1'b1;
                result_s    = 128'd0;
                rsp_valid_s = 1'b1;
              end else begin
                poll_cnt_s = poll_cnt_r + 16'd1;
              end
            end
            S_RD_DOUT: begin
              idx_s       = idx_r + 2'd1;
              result_s    = put_word(result_r, idx_r, io_wbm_dat_i);
              rsp_valid_s = last_word_s;
            end
            default: idx_s = idx_r;
          endcase
        end else if (timeout_s) begin
          cyc_s       = 1'b0;
          err_s       = 1'b1;
          result_s    = 128'd0;
          rsp_valid_s = 1'b1;
        end else begin
          to_cnt_s = to_cnt_r + 16'd1;
        end
      end
      S_RESP: begin
        ready_s = 1'b1;
      end
      default: begin
        cyc_s   = 1'b0;
        ready_s = 1'b0;
      end
    endcase
  end

  // Bus, datapath and response registers; reset drops cyc/stb at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc_r       <= 1'b0;
      we_r        <= 1'b0;
      adr_r       <= 32'd0;
      dat_r       <= 32'd0;
      idx_r       <= 2'd0;
      to_cnt_r    <= 16'd0;
      poll_cnt_r  <= 16'd0;
      key_r       <= 128'd0;
      din_r       <= 128'd0;
      dec_r       <= 1'b0;
      result_r    <= 128'd0;
      err_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      cyc_r       <= cyc_s;
      we_r        <= we_s;
      adr_r       <= adr_s;
      dat_r       <= dat_s;
      idx_r       <= idx_s;
      to_cnt_r    <= to_cnt_s;
      poll_cnt_r  <= poll_cnt_s;
      key_r       <= key_s;
      din_r       <= din_s;
      dec_r       <= dec_s;
      result_r    <= result_s;
      err_r       <= err_s;
      rsp_valid_r <= rsp_valid_s;
      ready_r     <= ready_s;
    end
  end

  assign io_cmd_ready = ready_r;
  assign io_rsp_valid = rsp_valid_r;
  assign io_rsp_data  = result_r;
  assign io_rsp_error = err_r;
  assign io_wbm_cyc_o = cyc_r;
  assign io_wbm_stb_o = cyc_r;
  assign io_wbm_we_o  = we_r;
  assign io_wbm_sel_o = {4{cyc_r}};
  assign io_wbm_adr_o = adr_r;
  assign io_wbm_dat_o = dat_r;

endmodule

// File: tb/tb_aes_wb_master.sv
module tb_aes_wb_master;
  localparam logic [31:0]  BASE = 32'h3000_0000;
  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clock;
  logic         reset;
  logic         cmd_valid, cmd_ready, cmd_decrypt, cmd_reuse_key;
  logic [127:0] cmd_key, cmd_data;
  logic         rsp_valid, rsp_error;
  logic [127:0] rsp_data;
  logic         wb_cyc, wb_stb, wb_we, wb_ack;
  logic [3:0]   wb_sel;
  logic [31:0]  wb_adr, wb_dat_o, wb_dat_i, off;

  int n_checks = 0;
  int n_errors = 0;

  aes_wb_master #(.BASE_ADDR(BASE), .ACK_TIMEOUT(16), .POLL_MAX(8)) dut (
    .clock(clock), .reset(reset),
    .io_cmd_valid(cmd_valid), .io_cmd_ready(cmd_ready),
    .io_cmd_decrypt(cmd_decrypt), .io_cmd_reuse_key(cmd_reuse_key),
    .io_cmd_key(cmd_key), .io_cmd_data(cmd_data),
    .io_rsp_valid(rsp_valid), .io_rsp_data(rsp_data), .io_rsp_error(rsp_error),
    .io_wbm_cyc_o(wb_cyc), .io_wbm_stb_o(wb_stb), .io_wbm_we_o(wb_we),
    .io_wbm_sel_o(wb_sel), .io_wbm_adr_o(wb_adr), .io_wbm_dat_o(wb_dat_o),
    .io_wbm_dat_i(wb_dat_i), .io_wbm_ack_i(wb_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- slave model ----------------
  int          wait_states = 0;
  int          done_on     = 1;   // STATUS read number that first reports done; 0 = never
  logic        noack       = 1'b0;
  logic        slave_clr   = 1'b1;
  int          wait_cnt, poll_cnt, stb_cycles, unstable, proto_bad;
  logic        ctrl_dec, in_acc, h_we;
  logic [31:0] h_adr, h_dat;
  logic [64:0] log_q[$];

  function automatic logic [31:0] wsel(input logic [127:0] b, input int w);
    return b[127 - 32*w -: 32];
  endfunction

  assign off    = wb_adr - BASE;
  assign wb_ack = wb_stb && !noack && (wait_cnt >= wait_states);

  always_comb begin
    wb_dat_i = 32'd0;
    if (off == 32'h24)
      wb_dat_i = {31'd0, (done_on != 0) && (poll_cnt + 1 >= done_on)};
    else if (off >= 32'h28 && off <= 32'h34)
      wb_dat_i = wsel(ctrl_dec ? PT : CT, int'((off - 32'h28) >> 2));
  end

  always @(posedge clock) begin
    if (slave_clr) begin
      wait_cnt <= 0; poll_cnt <= 0; ctrl_dec <= 1'b0; log_q.delete();
      stb_cycles <= 0; unstable <= 0; proto_bad <= 0; in_acc <= 1'b0;
    end else begin
      if (wb_cyc != wb_stb) proto_bad <= proto_bad + 1;
      if (wb_stb) begin
        stb_cycles <= stb_cycles + 1;
        if (wb_sel != 4'hF) proto_bad <= proto_bad + 1;
        if (in_acc && (wb_adr != h_adr || wb_dat_o != h_dat || wb_we != h_we))
          unstable <= unstable + 1;
        h_adr <= wb_adr; h_dat <= wb_dat_o; h_we <= wb_we;
        in_acc <= !wb_ack;
      end else begin
        in_acc <= 1'b0;
      end
      if (wb_stb && wb_ack) begin
        wait_cnt <= 0;
        log_q.push_back({wb_we, wb_adr, wb_we ? wb_dat_o : wb_dat_i});
        if (!wb_we && off == 32'h24) poll_cnt <= poll_cnt + 1;
        if (wb_we && off == 32'h20) ctrl_dec <= wb_dat_o[1];
      end else if (wb_stb) begin
        wait_cnt <= wait_cnt + 1;
      end else begin
        wait_cnt <= 0;
      end
    end
  end

  // ---------------- checking and stimulus ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_entry(input string tag, input int i, input logic we,
                             input logic [31:0] adr, input logic [31:0] d);
    if (i < log_q.size()) check(tag, 128'(log_q[i]), 128'({we, adr, d}));
    else check({tag, "_missing"}, 128'(log_q.size()), 128'(i + 1));
  endtask

  task automatic clr_slave();
    @(negedge clock); slave_clr = 1'b1;
    @(negedge clock); slave_clr = 1'b0;
  endtask

  task automatic start_cmd(input logic dec, input logic reuse,
                           input logic [127:0] k, input logic [127:0] d);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_decrypt = dec; cmd_reuse_key = reuse; cmd_key = k; cmd_data = d;
    @(negedge clock);
    cmd_valid = 1'b0; cmd_decrypt = 1'b0; cmd_reuse_key = 1'b0; cmd_key = 128'd0; cmd_data = 128'd0;
  endtask

  task automatic run_cmd(input string tag, input logic dec, input logic reuse,
                         input logic [127:0] k, input logic [127:0] d,
                         output int lat, output logic [127:0] rd, output logic re);
    start_cmd(dec, reuse, k, d);
    lat = 1;
    while (!rsp_valid && lat < 2000) begin
      @(negedge clock);
      lat++;
    end
    check({tag, "_rsp_seen"}, 128'(rsp_valid), 128'(1));
    rd = rsp_data; re = rsp_error;
    @(negedge clock);
    check({tag, "_ready_after"}, 128'(cmd_ready), 128'(1));
    check({tag, "_rsp_pulse"}, 128'(rsp_valid), 128'(0));
  endtask

  initial begin
    int lat, k;
    logic [127:0] rd;
    logic re;
    reset = 1'b0; cmd_valid = 1'b0; cmd_decrypt = 1'b0; cmd_reuse_key = 1'b0;
    cmd_key = 128'd0; cmd_data = 128'd0;
    repeat (3) @(negedge clock);
    check("rst_ready", 128'(cmd_ready), 128'(1));
    check("rst_cyc_stb", 128'({wb_cyc, wb_stb, wb_we, wb_sel}), 128'(0));
    check("rst_adr_dat", 128'({wb_adr, wb_dat_o}), 128'(0));
    check("rst_rsp", {rsp_valid, rsp_error, rsp_data[125:0]}, 128'(0));
    reset = 1'b1; slave_clr = 1'b0;

    // 1: zero-wait encrypt, full access sequence in map order
    run_cmd("t1", 1'b0, 1'b0, KEY, PT, lat, rd, re);
    check("t1_latency", 128'(lat), 128'(29));
    check("t1_data", rd, CT);
    check("t1_error", 128'(re), 128'(0));
    check("t1_count", 128'(log_q.size()), 128'(14));
    for (int i = 0; i < 4; i++) begin
      check_entry($sformatf("t1_key%0d", i), i, 1'b1, BASE + 32'(4*i), wsel(KEY, i));
      check_entry($sformatf("t1_din%0d", i), 4 + i, 1'b1, BASE + 32'h10 + 32'(4*i), wsel(PT, i));
      check_entry($sformatf("t1_dout%0d", i), 10 + i, 1'b0, BASE + 32'h28 + 32'(4*i), wsel(CT, i));
    end
    check_entry("t1_ctrl", 8, 1'b1, BASE + 32'h20, 32'h1);
    check_entry("t1_status", 9, 1'b0, BASE + 32'h24, 32'h1);
    check("t1_protocol", 128'(proto_bad), 128'(0));

    // 2: back-to-back decrypt reusing the key
    clr_slave();
    run_cmd("t2", 1'b1, 1'b1, 128'hdeadbeef, CT, lat, rd, re);
    check("t2_latency", 128'(lat), 128'(21));
    check("t2_data", rd, PT);
    check("t2_count", 128'(log_q.size()), 128'(10));
    check_entry("t2_first_din", 0, 1'b1, BASE + 32'h10, wsel(CT, 0));
    check_entry("t2_ctrl", 4, 1'b1, BASE + 32'h20, 32'h3);

    // 3: 3 wait states per access, done on the 5th STATUS read
    wait_states = 3; done_on = 5;
    clr_slave();
    run_cmd("t3", 1'b0, 1'b0, KEY, PT, lat, rd, re);
    check("t3_data", rd, CT);
    check("t3_error", 128'(re), 128'(0));
    check("t3_polls", 128'(poll_cnt), 128'(5));
    check("t3_count", 128'(log_q.size()), 128'(18));
    check("t3_stable", 128'(unstable), 128'(0));
    check("t3_protocol", 128'(proto_bad), 128'(0));

    // 4: first KEY write never acked -> timeout abort
    wait_states = 0; done_on = 1; noack = 1'b1;
    clr_slave();
    run_cmd("t4", 1'b0, 1'b0, KEY, PT, lat, rd, re);
    check("t4_latency", 128'(lat), 128'(18));
    check("t4_error", 128'(re), 128'(1));
    check("t4_data", rd, 128'd0);
    check("t4_stb_cycles", 128'(stb_cycles), 128'(16));
    check("t4_cyc_low", 128'(wb_cyc), 128'(0));
    noack = 1'b0;

    // 5: STATUS never done -> exactly POLL_MAX reads then error
    done_on = 0;
    clr_slave();
    run_cmd("t5", 1'b0, 1'b0, KEY, PT, lat, rd, re);
    check("t5_error", 128'(re), 128'(1));
    check("t5_data", rd, 128'd0);
    check("t5_polls", 128'(poll_cnt), 128'(8));
    check("t5_count", 128'(log_q.size()), 128'(17));

    // 6: reset in the middle of POLL, then a clean command
    clr_slave();
    start_cmd(1'b0, 1'b0, KEY, PT);
    k = 0;
    while (!(wb_stb && wb_adr == BASE + 32'h24) && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("t6_reached_poll", 128'(wb_stb && wb_adr == BASE + 32'h24), 128'(1));
    reset = 1'b0;
    #1;
    check("t6_cyc_stb_drop", 128'({wb_cyc, wb_stb}), 128'(0));
    check("t6_rsp_valid", 128'(rsp_valid), 128'(0));
    check("t6_ready", 128'(cmd_ready), 128'(1));
    @(negedge clock);
    reset = 1'b1; done_on = 1;
    clr_slave();
    run_cmd("t6b", 1'b0, 1'b0, KEY, PT, lat, rd, re);
    check("t6b_latency", 128'(lat), 128'(29));
    check("t6b_data", rd, CT);
    check("t6b_error", 128'(re), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
